// File: rtl/pwm_pkg.sv
// Shared widths, constants and the duty compare rule for the PWM peripheral.
// Latency: n/a (package). Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_CH    = 16;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
    typedef logic [NUM_CH-1:0]    ch_mask_t;

    localparam pwm_cnt_t DUTY_FULL = 8'hFF;

    // Full-scale duty is forced high so 0xFF gives a solid level instead of 255/256.
    function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; flags the last step of each period.
// Latency: period_start registered, high in the first cycle with pwm_cnt==0.
// Backpressure: none, free-running.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PWM_DIV = 12
) (
    input  logic     clk,
    input  logic     rst,
    output pwm_cnt_t pwm_cnt,
    output logic     boundary,
    output logic     period_start
);

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PWM_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    pwm_cnt_t         pwm_cnt_q, pwm_cnt_d;
    logic             period_start_q, period_start_d;
    logic             tick;

    always_comb begin
        tick           = (div_cnt_q == DIV_MAX);
        boundary       = tick && (pwm_cnt_q == DUTY_FULL);
        div_cnt_d      = tick ? '0 : div_cnt_q + 1'b1;
        pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        period_start_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_cnt      = pwm_cnt_q;
    assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel in-phase PWM / static output block with period-aligned duty update.
// Latency: out registered, one clk after enable, counter or duty-shadow change.
// Backpressure: none; inputs are sampled every cycle.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PWM_DIV = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    pwm_cnt_t pwm_cnt;
    logic     boundary;
    pwm_cnt_t duty_shadow_q, duty_shadow_d;
    ch_mask_t out_q, out_d;
    ch_mask_t en_out, en_pwm;
    logic     pwm_level;

    pwm_timebase #(
        .PWM_DIV (PWM_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .pwm_cnt      (pwm_cnt),
        .boundary     (boundary),
        .period_start (period_start)
    );

    // Duty is only captured as the counter rolls over, so a period is never cut short.
    always_comb begin
        en_out        = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm        = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        duty_shadow_d = boundary ? pwm_duty_cycle : duty_shadow_q;
        pwm_level     = pwm_compare(pwm_cnt, duty_shadow_q);
        out_d         = en_out & (~en_pwm | {NUM_CH{pwm_level}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_shadow_q <= '0;
            out_q         <= '0;
        end else begin
            duty_shadow_q <= duty_shadow_d;
            out_q         <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (PWM_DIV 4 and 1) checked each cycle against
// an arithmetic reference model, plus directed period-width measurements.
module tb_pwm_peripheral;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out_a, out_b;
    logic        ps_a, ps_b;
    logic [15:0] en_out_v, en_pwm_v;

    int n_assert = 0;
    int n_fail   = 0;

    assign en_out_v = {eo_hi, eo_lo};
    assign en_pwm_v = {ep_hi, ep_lo};

    always #5 clk = ~clk;

    pwm_peripheral #(.PWM_DIV(DIV_A)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out_a),
        .period_start    (ps_a)
    );

    pwm_peripheral #(.PWM_DIV(DIV_B)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out_b),
        .period_start    (ps_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: edges since reset n give pwm_cnt = (n / DIV) mod 256 directly.
    int          div_m [2] = '{DIV_A, DIV_B};
    int unsigned n_m   [2];
    logic [7:0]  shadow_m [2];
    logic [15:0] exp_out [2];
    logic        exp_ps  [2];

    always @(posedge clk or posedge rst) begin
        int   cnt;
        logic lvl;
        if (rst) begin
            for (int w = 0; w < 2; w++) begin
                n_m[w]      = 0;
                shadow_m[w] = 8'h00;
                exp_out[w]  = 16'h0000;
                exp_ps[w]   = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                cnt = int'((n_m[w] / div_m[w]) % 256);
                lvl = (shadow_m[w] == 8'hFF) || (cnt < int'(shadow_m[w]));
                for (int ch = 0; ch < 16; ch++)
                    exp_out[w][ch] = en_out_v[ch] ? (en_pwm_v[ch] ? lvl : 1'b1) : 1'b0;
                if (((n_m[w] + 1) % (256 * div_m[w])) == 0)
                    shadow_m[w] = duty;
                n_m[w]++;
                exp_ps[w] = ((n_m[w] % (256 * div_m[w])) == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_out_a", {16'h0, out_a}, {16'h0, exp_out[0]});
            chk("model_ps_a",  {31'h0, ps_a},  {31'h0, exp_ps[0]});
            chk("model_out_b", {16'h0, out_b}, {16'h0, exp_out[1]});
            chk("model_ps_b",  {31'h0, ps_b},  {31'h0, exp_ps[1]});
        end
    end

    // Advances at least one cycle, then stops on the next period_start sample.
    task automatic wait_ps(input int w);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 512 * div_m[w] + 4 && !found; k++) begin
            @(negedge clk);
            found = (w == 0) ? ps_a : ps_b;
        end
        chk("wait_period_start", {31'h0, found}, 32'h1);
    endtask

    task automatic measure(input int w, input int ch, input int len, input int chg_idx,
                           input logic [7:0] chg_duty,
                           output int highs, output int ps_cnt, output int contig);
        logic b;
        logic fell;
        highs  = 0;
        ps_cnt = 0;
        contig = 1;
        fell   = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            b = (w == 0) ? out_a[ch] : out_b[ch];
            if (b) begin
                highs++;
                if (fell) contig = 0;
            end else begin
                fell = 1'b1;
            end
            ps_cnt += (w == 0) ? int'(ps_a) : int'(ps_b);
            if (k == chg_idx) duty = chg_duty;
        end
    endtask

    initial begin
        int h, p, c;
        rst = 1'b1;
        eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00; duty = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_out_a", {16'h0, out_a}, 32'h0);
        chk("rst_ps_a",  {31'h0, ps_a},  32'h0);
        chk("rst_out_b", {16'h0, out_b}, 32'h0);
        chk("rst_ps_b",  {31'h0, ps_b},  32'h0);

        // First period after reset is low for PWM channels; static channel on at once.
        eo_lo = 8'h03; ep_lo = 8'h01; duty = 8'h80;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("static_on_after_rst", {31'h0, out_a[1]}, 32'h1);
        chk("pwm_low_after_rst",   {31'h0, out_a[0]}, 32'h0);
        measure(0, 0, 1023, -1, 8'h00, h, p, c);
        chk("first_period_high", h, 0);
        chk("first_period_ps",   p, 1);
        measure(0, 0, 1024, -1, 8'h00, h, p, c);
        chk("duty80_high",   h, 512);
        chk("duty80_contig", c, 1);
        chk("duty80_ps",     p, 1);

        // Channel 5: 0x80 still active, then 0x00, then 0xFF from the following period.
        eo_lo = 8'h21; ep_lo = 8'h21; duty = 8'h00;
        measure(0, 5, 1024, -1, 8'h00, h, p, c);
        chk("ch5_old_duty_high", h, 512);
        measure(0, 5, 1024, 100, 8'hFF, h, p, c);
        chk("ch5_duty00_high", h, 0);
        measure(0, 5, 1024, -1, 8'h00, h, p, c);
        chk("ch5_dutyFF_high", h, 1024);

        // Static outputs follow enables with one cycle latency.
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'h00; ep_hi = 8'h00;
        @(negedge clk);
        chk("static_all_on_a", {16'h0, out_a}, 32'hFFFF);
        chk("static_all_on_b", {16'h0, out_b}, 32'hFFFF);
        eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'hFF; ep_hi = 8'hFF;
        @(negedge clk);
        chk("static_all_off_a", {16'h0, out_a}, 32'h0);
        chk("static_all_off_b", {16'h0, out_b}, 32'h0);

        // Mid-period duty write only lands at the next boundary.
        eo_lo = 8'h01; ep_lo = 8'h01; ep_hi = 8'h00; duty = 8'h40;
        wait_ps(0);
        measure(0, 0, 1024, 64, 8'hC0, h, p, c);
        chk("duty40_kept_high", h, 256);
        chk("duty40_contig",    c, 1);
        measure(0, 0, 1024, -1, 8'h00, h, p, c);
        chk("dutyC0_high", h, 768);

        // Reset in the middle of a period.
        eo_lo = 8'h03; ep_lo = 8'h01; duty = 8'h80;
        wait_ps(0);
        repeat (16'h240) @(negedge clk);
        chk("pre_rst_out_a", {16'h0, out_a}, 32'h0002);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_a", {16'h0, out_a}, 32'h0);
        chk("mid_rst_ps_a",  {31'h0, ps_a},  32'h0);
        @(negedge clk);
        rst = 1'b0;
        measure(0, 0, 1024, -1, 8'h00, h, p, c);
        chk("post_rst_first_high", h, 0);
        chk("post_rst_first_ps",   p, 1);
        measure(0, 0, 1024, -1, 8'h00, h, p, c);
        chk("post_rst_second_high", h, 512);

        // PWM_DIV=1 instance with minimum non-zero duty.
        duty = 8'h01;
        wait_ps(1);
        for (int r = 0; r < 2; r++) begin
            measure(1, 0, 256, -1, 8'h00, h, p, c);
            chk("div1_duty01_high", h, 1);
            chk("div1_ps_per_256",  p, 1);
            chk("div1_contig",      c, 1);
        end

        // Random enables and duty writes, checked by the per-cycle model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(63) == 0) begin
                {eo_hi, eo_lo} = 16'($urandom);
                {ep_hi, ep_lo} = 16'($urandom);
            end
            if ($urandom_range(199) == 0)
                duty = 8'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PWM_DIV, default 12, clock cycles per PWM counter step; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enable, channels 7..0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  shared duty value, 0x00..0xFF.
REQ-009 SHALL have port out  output  16  channel outputs, registered.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse marking the start of each PWM period.
REQ-011 SHALL treat all inputs as synchronous to clk; the upstream register file already sits in the clk domain, so no synchronizers.

Function
REQ-012 SHALL have prescaler div_cnt counting 0..PWM_DIV-1 and wrapping to 0; tick = (div_cnt == PWM_DIV-1); PWM_DIV=1 gives tick every cycle.
REQ-013 SHALL have 8-bit pwm_cnt that increments on tick only, wrapping 0xFF->0x00; period = 256*PWM_DIV clocks.
REQ-014 SHALL load duty_shadow from pwm_duty_cycle only in the cycle where tick and pwm_cnt==0xFF, i.e. when pwm_cnt becomes 0x00.
REQ-015 SHALL ignore pwm_duty_cycle changes mid-period; they take effect at the next period boundary; no glitch or truncated pulse.
REQ-016 SHALL register period_start <= tick && pwm_cnt==0xFF, so it is high exactly in the first cycle with pwm_cnt==0x00.
REQ-017 SHALL compute pwm_level = 1 when duty_shadow==0xFF, else (pwm_cnt < duty_shadow); 0x00 gives constant low, 0xFF constant high, N otherwise gives N*PWM_DIV high clocks per period.
REQ-018 SHALL register out[i] <= en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0, where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
REQ-019 SHALL give out one clk of latency after any change of enables, pwm_cnt or duty_shadow.
REQ-020 SHALL apply enable changes on the next clk edge (not period-aligned); en_out=0 overrides en_pwm.
REQ-021 SHALL drive all 16 PWM channels in phase from the one shared pwm_cnt and duty_shadow.
REQ-022 SHALL handle simultaneous boundary tick and duty change by loading the pwm_duty_cycle value present in that cycle.

Reset
REQ-023 SHALL, while rst=1, asynchronously force div_cnt=0, pwm_cnt=0x00, duty_shadow=0x00, out=0x0000, period_start=0.
REQ-024 SHALL, after rst deasserts, output PWM-mode channels low for the whole first period, because duty_shadow=0 until the first boundary; static-on channels go high one cycle after rst falls.
REQ-025 SHALL, on reset mid-period, abort the period; counting restarts from 0 with no period_start pulse emitted for the aborted period.

Structure
REQ-026 SHALL place PWM_CNT_W (8), NUM_CH (16) and DUTY_FULL (8'hFF) in shared package pwm_pkg.
REQ-027 SHALL implement prescaler, pwm_cnt, tick and period_start in sub-module pwm_timebase; pwm_peripheral holds duty_shadow, compare and output mux.

Verification
REQ-028 SHALL cover: PWM_DIV=4, duty=0x80, en_out[0]=en_pwm[0]=1 -> out[0] high 512 clocks, low 512 clocks per 1024-clock period, aligned to period_start.
REQ-029 SHALL cover: duty=0x00 and then 0xFF, PWM mode ch 5 -> out[5] constant 0, then constant 1 from the period after the change.
REQ-030 SHALL cover: en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF one cycle later; en_out cleared -> out=0x0000 one cycle later.
REQ-031 SHALL cover: duty 0x40 -> 0xC0 written at pwm_cnt=0x10 -> current period keeps 0x40 high width; next period shows 0xC0*PWM_DIV high.
REQ-032 SHALL cover: rst pulsed at pwm_cnt=0x90 with duty=0x80 -> out=0 immediately; first period after reset all low; second period 50% duty.
REQ-033 SHALL cover: PWM_DIV=1, duty=0x01 -> out high exactly 1 clock per 256, period_start every 256 clocks.
